// File: rtl/trace_pkg.sv
`default_nettype none
// ============================================================================
// Module   : trace_pkg
// Brief    : Shared types for the retired-instruction trace recorder.
// Revision : 1.0 - initial release
// ============================================================================
package trace_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        BEAT2 = 2'd3
    } rd_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] result;
    } trace_entry_t;

    localparam int TRACE_BEATS = 3;

    // Field of an entry presented on the stream for a given read state.
    function automatic logic [31:0] beat_word(input trace_entry_t e, input rd_state_t s);
        case (s)
            BEAT0:   return e.pc;
            BEAT1:   return e.instr;
            BEAT2:   return e.result;
            default: return 32'h0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/trace_capture_if.sv
`default_nettype none
// ============================================================================
// Module   : trace_capture_if
// Brief    : Capture bus from the core plus the host read stream.
//            master = core/host side, slave = trace recorder.
// Revision : 1.0 - initial release
// ============================================================================
interface trace_capture_if;
    logic        cap_valid;
    logic [31:0] cap_pc;
    logic [31:0] cap_instr;
    logic [31:0] cap_result;
    logic        host_ready;
    logic        host_valid;
    logic [31:0] host_data;
    logic        host_last;

    modport master (
        output cap_valid, cap_pc, cap_instr, cap_result, host_ready,
        input  host_valid, host_data, host_last
    );

    modport slave (
        input  cap_valid, cap_pc, cap_instr, cap_result, host_ready,
        output host_valid, host_data, host_last
    );
endinterface
`default_nettype wire

// File: rtl/trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : trace_fifo
// Brief    : Entry storage with head/tail pointers and occupancy count.
//            A push while full is accepted only if a pop frees a slot in
//            the same edge.
// Revision : 1.0 - initial release
// ============================================================================
module trace_fifo
    import trace_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         push,
    input  wire logic         pop,
    input  wire trace_entry_t wr_entry,
    output trace_entry_t      head_entry,
    output logic [AW:0]       count,
    output logic              empty,
    output logic              push_ok
);

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    trace_entry_t    mem [DEPTH];
    logic [AW-1:0]   head;
    logic [AW-1:0]   tail;
    logic            full;
    logic            pop_ok;

    assign full       = (count == FULL_COUNT);
    assign empty      = (count == '0);
    assign pop_ok     = pop & ~empty;
    assign push_ok    = push & (~full | pop_ok);
    assign head_entry = mem[head];

    // Entry storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail] <= wr_entry;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) tail <= tail + AW'(1);
            if (pop_ok)  head <= head + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : trace_capture
// Brief    : Retired-instruction trace recorder. Buffers {pc, instr, result}
//            entries and streams them to a host as three 32-bit beats.
// Revision : 1.0 - initial release
// ============================================================================
module trace_capture
    import trace_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        en,
    input  wire logic        clr_ovf,
    trace_capture_if.slave   bus,
    output logic [AW:0]      count,
    output logic             overflow
);

    rd_state_t    state;
    rd_state_t    state_nxt;
    trace_entry_t head_entry;
    trace_entry_t wr_entry;
    logic         cap_req;
    logic         push_ok;
    logic         fifo_empty;
    logic         pop;

    assign cap_req  = en & bus.cap_valid;
    assign wr_entry = '{pc: bus.cap_pc, instr: bus.cap_instr, result: bus.cap_result};
    assign pop      = (state == BEAT2) & bus.host_ready;

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (cap_req),
        .pop        (pop),
        .wr_entry   (wr_entry),
        .head_entry (head_entry),
        .count      (count),
        .empty      (fifo_empty),
        .push_ok    (push_ok)
    );

    // Sticky drop flag; a drop in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (cap_req & ~push_ok) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Read FSM next state and beat outputs. Leaving EMPTY on the push itself
    // gives the one-cycle push-to-valid latency.
    always_comb begin
        state_nxt      = state;
        bus.host_valid = 1'b0;
        bus.host_last  = 1'b0;
        bus.host_data  = beat_word(head_entry, state);
        case (state)
            EMPTY: begin
                if (!fifo_empty || push_ok) state_nxt = BEAT0;
            end
            BEAT0: begin
                bus.host_valid = 1'b1;
                if (bus.host_ready) state_nxt = BEAT1;
            end
            BEAT1: begin
                bus.host_valid = 1'b1;
                if (bus.host_ready) state_nxt = BEAT2;
            end
            BEAT2: begin
                bus.host_valid = 1'b1;
                bus.host_last  = 1'b1;
                if (bus.host_ready) begin
                    state_nxt = (count > (AW + 1)'(1) || push_ok) ? BEAT0 : EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_trace_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_capture
// Brief    : Scoreboard bench for trace_capture with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_capture;
    import trace_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          rst;
    logic          en;
    logic          clr_ovf;
    logic [AW:0]   count;
    logic          overflow;

    trace_capture_if ifc ();

    trace_capture #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr_ovf  (clr_ovf),
        .bus      (ifc),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: entries stored, beats consumed of head entry, sticky flag,
    // and the ordered list of words the host should see.
    int          m_cnt  = 0;
    int          m_beat = 0;
    bit          m_ovf  = 0;
    logic [31:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Model update at each active edge; expected words queued on acceptance.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt  = 0;
            m_beat = 0;
            m_ovf  = 0;
            exp_q.delete();
        end else begin
            bit hs, pop_e, req, acc;
            hs    = (m_cnt > 0) && ifc.host_ready;
            pop_e = hs && (m_beat == TRACE_BEATS - 1);
            req   = en && ifc.cap_valid;
            acc   = req && ((m_cnt < DEPTH) || pop_e);
            if (hs) m_beat = pop_e ? 0 : m_beat + 1;
            m_cnt = m_cnt + (acc ? 1 : 0) - (pop_e ? 1 : 0);
            if (acc) begin
                exp_q.push_back(ifc.cap_pc);
                exp_q.push_back(ifc.cap_instr);
                exp_q.push_back(ifc.cap_result);
            end
            if (req && !acc) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
        end
    end

    // Monitor: compares the presented stream and status against the model.
    always @(negedge clk) begin
        if (rst) begin
            chk("host_valid", 32'(ifc.host_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("host_data", ifc.host_data, exp_q[0]);
                chk("host_last", 32'(ifc.host_last), 32'((exp_q.size() % TRACE_BEATS) == 1));
                if (ifc.host_ready) void'(exp_q.pop_front());
            end else begin
                chk("host_last_idle", 32'(ifc.host_last), 32'h0);
            end
            chk("count", 32'(count), 32'(m_cnt));
            chk("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] res);
        ifc.cap_valid  = 1'b1;
        ifc.cap_pc     = pc;
        ifc.cap_instr  = instr;
        ifc.cap_result = res;
        tick();
        ifc.cap_valid  = 1'b0;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_valid"}, 32'(ifc.host_valid), 32'h0);
        chk({tag, "_last"},  32'(ifc.host_last),  32'h0);
        chk({tag, "_data"},  ifc.host_data,       32'h0);
        chk({tag, "_count"}, 32'(count),          32'h0);
        chk({tag, "_ovf"},   32'(overflow),       32'h0);
    endtask

    initial begin
        rst            = 1'b0;
        en             = 1'b0;
        clr_ovf        = 1'b0;
        ifc.cap_valid  = 1'b0;
        ifc.cap_pc     = '0;
        ifc.cap_instr  = '0;
        ifc.cap_result = '0;
        ifc.host_ready = 1'b0;

        // Reset state
        #3;
        check_cleared("in_reset");
        tick();
        rst = 1'b1;
        tick();
        check_cleared("after_reset");

        // Single entry, reader always ready
        en = 1'b1;
        ifc.host_ready = 1'b1;
        push_entry(32'h0000_0004, 32'h0050_0093, 32'h0000_0005);
        chk("single_count", 32'(count), 32'd1);
        repeat (5) tick();

        // Backpressure while in BEAT1
        ifc.host_ready = 1'b0;
        push_entry(32'h0000_0004, 32'h0050_0093, 32'h0000_0005);
        ifc.host_ready = 1'b1;
        tick();
        ifc.host_ready = 1'b0;
        repeat (5) tick();
        chk("bp_hold_data", ifc.host_data, 32'h0050_0093);
        ifc.host_ready = 1'b1;
        tick();
        chk("bp_beat2_data", ifc.host_data, 32'h0000_0005);
        repeat (3) tick();

        // Overflow: 18 pushes without reads
        ifc.host_ready = 1'b0;
        for (int i = 0; i < 18; i++) push_entry(32'(4 * i), $urandom, $urandom);
        chk("full_count", 32'(count), 32'd16);
        chk("full_ovf", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        clr_ovf = 1'b1;
        push_entry(32'hDEAD_0000, $urandom, $urandom);
        clr_ovf = 1'b0;
        chk("clr_vs_drop", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;

        // Full push/pop collision in BEAT2
        ifc.host_ready = 1'b1;
        repeat (2) tick();
        push_entry(32'h0000_0100, $urandom, $urandom);
        chk("collide_count", 32'(count), 32'd16);
        chk("collide_ovf", 32'(overflow), 32'd0);
        repeat (52) tick();
        chk("drain_count", 32'(count), 32'd0);

        // Qualification
        en = 1'b0;
        ifc.cap_valid = 1'b1;
        repeat (3) tick();
        chk("en0_count", 32'(count), 32'd0);
        en = 1'b1;
        ifc.cap_valid = 1'b0;
        repeat (3) tick();
        chk("valid0_count", 32'(count), 32'd0);
        ifc.host_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_entry($urandom, $urandom, $urandom);
        ifc.host_ready = 1'b1;
        repeat (4) tick();
        en = 1'b0;
        ifc.cap_valid = 1'b1;
        repeat (12) tick();
        ifc.cap_valid = 1'b0;
        chk("en_drain_count", 32'(count), 32'd0);

        // Randomized traffic with an asynchronous reset in the middle
        for (int c = 0; c < 600; c++) begin
            en             = ($urandom_range(7) != 0);
            ifc.cap_valid  = ($urandom_range(1) != 0);
            ifc.cap_pc     = $urandom;
            ifc.cap_instr  = $urandom;
            ifc.cap_result = $urandom;
            ifc.host_ready = (c % 100 < 70) ? ($urandom_range(3) != 0) : 1'b0;
            clr_ovf        = ($urandom_range(15) == 0);
            if (c == 330) begin
                #2;
                rst = 1'b0;
                #1;
                check_cleared("async_reset");
                @(posedge clk);
                #1;
                rst = 1'b1;
            end else begin
                tick();
            end
        end

        // Final drain
        en             = 1'b0;
        ifc.cap_valid  = 1'b0;
        clr_ovf        = 1'b0;
        ifc.host_ready = 1'b1;
        repeat (60) tick();
        chk("final_count", 32'(count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
